uart_chunk_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx_typed_chunker` between `NUM_REQ` requesters. It accepts a chunk from one requester at a time and latches the chunk's bytes, size and type. It drives the chunker's chunk inputs and start pulse, then tracks the transfer by counting the chunker's per-byte triggers until the chunker is idle again. It sits between producer blocks (sensor packers, status reporters) and the chunker → UART TX pair.

---
 rtl/uart_chunk_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 21 ++
 rtl/uart_chunk_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_chunk_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_chunk_pkg.sv
// uart_chunk_pkg: state encoding and framing constants shared by the chunk arbiter
package uart_chunk_pkg;
    typedef enum logic [2:0] {
        ST_WAIT_SYNC,
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_TAIL,
        ST_SETTLE
    } state_t;
    localparam logic [1:0] GUARD_LEN = 2'd2;
    localparam int HDR_BYTES = 2;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin picker, first request strictly after the pointer wins
module rr_priority_pick #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_valid
);
    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= N; k++)
            for (int j = 0; j < N; j++)
                if (!o_valid && i_req[j] && j == (int'(i_ptr) + k) % N) begin
                    o_grant[j] = 1'b1;
                    o_valid    = 1'b1;
                end
    end
endmodule

// File: rtl/uart_chunk_arbiter.sv
// uart_chunk_arbiter: round-robin scheduler sharing one typed chunker between several requesters
module uart_chunk_arbiter
    import uart_chunk_pkg::*;
#(
    parameter int NUM_REQ           = 2,
    parameter int BUFFER_BYTE_SIZE  = 3,
    parameter int BUFFER_INDEX_SIZE = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_REQ-1:0]                    i_req_chunk_ready,
    input  logic [NUM_REQ*BUFFER_BYTE_SIZE*8-1:0] i_req_chunk_bytes,
    input  logic [NUM_REQ*BUFFER_INDEX_SIZE-1:0]  i_req_chunk_byte_size,
    input  logic [NUM_REQ*8-1:0]                  i_req_chunk_type,
    output logic [NUM_REQ-1:0]                    o_req_ack,
    output logic [NUM_REQ-1:0]                    o_req_done,
    output logic                                  o_req_rejected,
    output logic                                  o_chunk_ready,
    output logic [BUFFER_INDEX_SIZE-1:0]          o_chunk_byte_size,
    output logic [BUFFER_BYTE_SIZE*8-1:0]         o_chunk_bytes,
    output logic [7:0]                            o_chunk_type,
    input  logic                                  i_chunker_tx_ready,
    input  logic                                  i_is_tx_done,
    output logic                                  o_busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BW    = BUFFER_BYTE_SIZE * 8;
    localparam int IW    = BUFFER_INDEX_SIZE;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [IW-1:0]      r_count;
    logic [1:0]         r_guard;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic               r_rejected;
    logic               r_chunk_ready;
    logic               r_busy;
    logic [IW-1:0]      r_size;
    logic [BW-1:0]      r_bytes;
    logic [7:0]         r_type;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_valid;
    logic [PTR_W-1:0]   w_idx;
    logic [IW-1:0]      w_size;
    logic [BW-1:0]      w_bytes;
    logic [7:0]         w_type;
    logic               w_illegal;
    logic [IW-1:0]      w_expected;
    logic [IW-1:0]      w_count_inc;

    rr_priority_pick #(.N(NUM_REQ)) u_pick (
        .i_req   (i_req_chunk_ready),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    always_comb begin
        w_idx   = '0;
        w_size  = '0;
        w_bytes = '0;
        w_type  = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (w_grant[i]) begin
                w_idx   = PTR_W'(i);
                w_size  = i_req_chunk_byte_size[i*IW +: IW];
                w_bytes = i_req_chunk_bytes[i*BW +: BW];
                w_type  = i_req_chunk_type[i*8 +: 8];
            end
    end

    assign w_illegal = (w_size == '0) || (w_size > IW'(BUFFER_BYTE_SIZE)) || (w_type == 8'h00);

    // Every payload 0x00 is escaped by the chunker into two wire bytes
    always_comb begin
        w_expected = IW'(HDR_BYTES) + r_size;
        for (int k = 0; k < BUFFER_BYTE_SIZE; k++)
            if (IW'(k) < r_size && r_bytes[k*8 +: 8] == 8'h00)
                w_expected = w_expected + 1'b1;
    end

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_WAIT_SYNC;
            r_ptr         <= PTR_W'(NUM_REQ - 1);
            r_count       <= '0;
            r_guard       <= '0;
            r_ack         <= '0;
            r_done        <= '0;
            r_rejected    <= 1'b0;
            r_chunk_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_size        <= '0;
            r_bytes       <= '0;
            r_type        <= '0;
        end else begin
            r_ack         <= '0;
            r_done        <= '0;
            r_rejected    <= 1'b0;
            r_chunk_ready <= 1'b0;
            case (r_state)
                ST_WAIT_SYNC: begin
                    r_busy <= !i_is_tx_done;
                    if (i_is_tx_done) r_state <= ST_IDLE;
                end
                ST_IDLE: if (w_valid) begin
                    r_ptr   <= w_idx;
                    r_ack   <= w_grant;
                    r_size  <= w_size;
                    r_bytes <= w_bytes;
                    r_type  <= w_type;
                    if (w_illegal) r_rejected <= 1'b1;
                    else begin
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_chunk_ready <= 1'b1;
                    r_count       <= '0;
                    r_state       <= ST_SEND;
                end
                ST_SEND: if (i_chunker_tx_ready) begin
                    r_count <= w_count_inc;
                    if (w_count_inc == w_expected) begin
                        r_guard <= '0;
                        r_state <= ST_TAIL;
                    end
                end
                // Guard lets the UART drop is_tx_done for the last byte before we trust it
                ST_TAIL: if (r_guard != GUARD_LEN) r_guard <= r_guard + 1'b1;
                else if (i_is_tx_done) begin
                    r_done[r_ptr] <= 1'b1;
                    r_state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_WAIT_SYNC;
            endcase
        end
    end

    assign o_req_ack         = r_ack;
    assign o_req_done        = r_done;
    assign o_req_rejected    = r_rejected;
    assign o_chunk_ready     = r_chunk_ready;
    assign o_chunk_byte_size = r_size;
    assign o_chunk_bytes     = r_bytes;
    assign o_chunk_type      = r_type;
    assign o_busy            = r_busy;
endmodule

// File: tb/tb_uart_chunk_arbiter.sv
// tb_uart_chunk_arbiter: randomized bench with a behavioural chunker and round-robin reference model
module tb_uart_chunk_arbiter;
    localparam int NR = 2;
    localparam int BB = 3;
    localparam int IW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NR-1:0]      req_ready = '0;
    logic [NR*BB*8-1:0] req_bytes = '0;
    logic [NR*IW-1:0]   req_size = '0;
    logic [NR*8-1:0]    req_type = '0;
    logic               tx_ready = 1'b0;
    logic               tx_done = 1'b0;
    logic [NR-1:0]      ack;
    logic [NR-1:0]      done;
    logic               rejected;
    logic               chunk_ready;
    logic [IW-1:0]      chunk_size;
    logic [BB*8-1:0]    chunk_bytes;
    logic [7:0]         chunk_type;
    logic               busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = -1;
    int ptr = NR - 1;
    int sz[NR];
    logic [7:0] ty[NR];
    logic [BB*8-1:0] by[NR];
    bit stray;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_chunk_arbiter #(.NUM_REQ(NR), .BUFFER_BYTE_SIZE(BB), .BUFFER_INDEX_SIZE(IW)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_req_chunk_ready     (req_ready),
        .i_req_chunk_bytes     (req_bytes),
        .i_req_chunk_byte_size (req_size),
        .i_req_chunk_type      (req_type),
        .o_req_ack             (ack),
        .o_req_done            (done),
        .o_req_rejected        (rejected),
        .o_chunk_ready         (chunk_ready),
        .o_chunk_byte_size     (chunk_size),
        .o_chunk_bytes         (chunk_bytes),
        .o_chunk_type          (chunk_type),
        .i_chunker_tx_ready    (tx_ready),
        .i_is_tx_done          (tx_done),
        .o_busy                (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal(input int r);
        return sz[r] != 0 && sz[r] <= BB && ty[r] != 8'h00;
    endfunction

    function automatic int wire_bytes(input int r);
        int n = 2 + sz[r];
        for (int k = 0; k < sz[r]; k++) if (by[r][k*8 +: 8] == 8'h00) n++;
        return n;
    endfunction

    task automatic drive(input logic [NR-1:0] mask);
        req_ready = mask;
        for (int i = 0; i < NR; i++) begin
            req_bytes[i*BB*8 +: BB*8] = by[i];
            req_size[i*IW +: IW] = sz[i];
            req_type[i*8 +: 8] = ty[i];
        end
    endtask

    task automatic rand_req(input int r, input bit any);
        sz[r] = int'($urandom_range(1, BB));
        ty[r] = 8'($urandom_range(1, 255));
        if (any && $urandom_range(0, 5) == 0) sz[r] = ($urandom_range(0, 1) == 0) ? 0 : BB + 1;
        if (any && $urandom_range(0, 7) == 0) ty[r] = 8'h00;
        for (int k = 0; k < BB; k++)
            by[r][k*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    endtask

    // One arbitration plus, if legal, a full chunker transfer; rst_at aborts after that byte
    task automatic run(input logic [NR-1:0] mask, input int rst_at);
        int w, t, n;
        bit early;
        w = -1;
        for (int k = 1; k <= NR; k++) if (w < 0 && mask[(ptr + k) % NR]) w = (ptr + k) % NR;
        drive(mask);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (ack == '0 && t < 100);
        chk("ack", 64'(ack), 64'(1) << w);
        chk("rejected", 64'(rejected), 64'(!legal(w)));
        ptr = w;
        req_ready = '0;
        req_bytes[w*BB*8 +: BB*8] = (BB*8)'($urandom);
        req_size[w*IW +: IW] = $urandom;
        req_type[w*8 +: 8] = 8'($urandom);
        if (!legal(w)) begin
            @(negedge clk);
            chk("rej_no_start", 64'(chunk_ready), 64'(0));
            chk("rej_idle", 64'(busy), 64'(0));
            return;
        end
        chk("busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("start", 64'(chunk_ready), 64'(1));
        chk("bytes", 64'(chunk_bytes), 64'(by[w]));
        chk("size", 64'(chunk_size), 64'(sz[w]));
        chk("type", 64'(chunk_type), 64'(ty[w]));
        if (last_done >= 0) chk("gap", 64'((cyc - last_done) >= 3), 64'(1));
        n = wire_bytes(w);
        early = 1'b0;
        @(negedge clk);
        chk("start_once", 64'(chunk_ready), 64'(0));
        for (int b = 0; b < n; b++) begin
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
            tx_done = 1'b0;
            if (b == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_ctl", 64'({ack, done, rejected, chunk_ready, busy}), 64'(0));
                chk("rst_data", {chunk_size, chunk_bytes, chunk_type}, 64'(0));
                ptr = NR - 1;
                last_done = -1;
                return;
            end
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                early |= (done != '0);
            end
            tx_done = 1'b1;
            if (b < n - 1)
                repeat ($urandom_range(3, 5)) begin
                    @(negedge clk);
                    early |= (done != '0);
                end
        end
        chk("no_early_done", 64'(early), 64'(0));
        t = 0;
        while (done == '0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done", 64'(done), 64'(1) << w);
        chk("hold_bytes", 64'(chunk_bytes), 64'(by[w]));
        last_done = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({ack, done, rejected, chunk_ready, busy}), 64'(0));
        chk("reset_data", {chunk_size, chunk_bytes, chunk_type}, 64'(0));
        rst_n = 1'b1;
        sz[0] = 3; ty[0] = 8'h07; by[0] = 24'h434241;
        sz[1] = 3; ty[1] = 8'h02; by[1] = 24'h005500;
        drive(2'b01);
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            stray |= (ack != '0);
        end
        chk("wait_sync_hold", 64'(stray), 64'(0));
        tx_done = 1'b1;
        run(2'b01, -1);
        run(2'b10, -1);
        for (int i = 0; i < 4; i++) begin
            rand_req(0, 1'b0);
            rand_req(1, 1'b0);
            run(2'b11, -1);
        end
        rand_req(0, 1'b0);
        sz[0] = 0;     run(2'b01, -1);
        sz[0] = BB + 1; run(2'b01, -1);
        sz[0] = BB; ty[0] = 8'h00; run(2'b01, -1);
        sz[0] = 1; ty[0] = 8'h11; by[0] = 24'hABCD00; run(2'b01, -1);
        sz[1] = 3; ty[1] = 8'h22; by[1] = 24'h000000; run(2'b10, -1);
        sz[0] = 3; ty[0] = 8'h33; by[0] = 24'h123456; run(2'b01, 1);
        @(negedge clk);
        tx_done = 1'b0;
        req_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_req(1, 1'b0);
        drive(2'b10);
        stray = 1'b0;
        repeat (50) begin
            tx_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            stray |= (ack != '0);
        end
        tx_ready = 1'b0;
        chk("post_reset_no_grant", 64'(stray), 64'(0));
        tx_done = 1'b1;
        run(2'b10, -1);
        for (int i = 0; i < 30; i++) begin
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            run(NR'($urandom_range(1, (1 << NR) - 1)), -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
